tsbus_oe_sequencer: RTL

- Generates the output-enable (oe) signals for N tri-state pad drivers that share one bus net.
- Sits directly upstream of the ts_pad instances; each oe[i] output connects to the oe input of pad i.
- Guarantees at most one enable is asserted at any time, inserts idle turnaround cycles between owners, and arbitrates round-robin with a hold limit.
- Downstream, driver-count checks on the bus must never report more than one active driver.

---
 rtl/tsbus_oe_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tsbus_oe_sequencer.sv
// Output-enable sequencer for N tri-state pad drivers sharing one net: oe is one-hot or zero,
// round-robin arbitration with a hold limit and TURN idle cycles between owners; req->oe is 1 cycle.
module tsbus_oe_sequencer #(
   parameter int N_DRV    = 4,
   parameter int TURN     = 1,
   parameter int MAX_HOLD = 8,
   localparam int OW      = (N_DRV > 1) ? $clog2(N_DRV) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_DRV-1:0] i_req,
   output logic [N_DRV-1:0] o_oe,
   output logic [OW-1:0]    o_owner,
   output logic             o_bus_busy,
   output logic             o_preempt,
   output logic [15:0]      o_grant_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

   localparam logic [7:0]    HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [3:0]    TURN_LOAD = 4'(TURN - 1);
   localparam logic [OW-1:0] LAST_IDX  = OW'(N_DRV - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_DRV-1:0] r_oe;
   logic [N_DRV-1:0] w_oe_nxt;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    w_owner_nxt;
   logic [OW-1:0]    r_rr_ptr;
   logic [OW-1:0]    w_rr_nxt;
   logic [OW-1:0]    w_win_idx;
   logic [7:0]       r_hold_cnt;
   logic [7:0]       w_hold_nxt;
   logic [3:0]       r_turn_cnt;
   logic [3:0]       w_turn_nxt;
   logic             r_busy;
   logic             r_preempt;
   logic             w_preempt_nxt;
   logic             w_win_vld;
   logic             w_grant;
   logic             w_release;
   logic             w_other_req;
   logic [N_DRV-1:0] w_own_mask;
   logic [15:0]      r_grant_cnt;
   logic [15:0]      w_grant_cnt_nxt;
   int               w_idx;

   // Round-robin search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = '0;
      w_idx     = 0;
      for (int k = 0; k < N_DRV; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= N_DRV) begin
            w_idx = w_idx - N_DRV;
         end
         if (!w_win_vld && i_req[w_idx]) begin
            w_win_vld = 1'b1;
            w_win_idx = OW'(w_idx);
         end
      end
   end

   assign w_own_mask  = N_DRV'(1) << r_owner;
   assign w_other_req = |(i_req & ~w_own_mask);

   always_comb begin
      w_state_nxt   = r_state;
      w_oe_nxt      = r_oe;
      w_owner_nxt   = r_owner;
      w_rr_nxt      = r_rr_ptr;
      w_hold_nxt    = r_hold_cnt;
      w_turn_nxt    = r_turn_cnt;
      w_preempt_nxt = 1'b0;
      w_grant       = 1'b0;
      w_release     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_grant = w_win_vld;
         end
         S_OWN: begin
            // A voluntary drop wins over the hold limit, so no preempt pulse then.
            if (!i_req[r_owner]) begin
               w_release = 1'b1;
            end else if (r_hold_cnt == HOLD_LAST && w_other_req) begin
               w_release     = 1'b1;
               w_preempt_nxt = 1'b1;
            end else if (r_hold_cnt != HOLD_LAST) begin
               w_hold_nxt = r_hold_cnt + 8'd1;
            end
         end
         S_TURN: begin
            if (r_turn_cnt != 4'd0) begin
               w_turn_nxt = r_turn_cnt - 4'd1;
            end else if (w_win_vld) begin
               w_grant = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = '0;
         end
      endcase

      if (w_grant) begin
         w_state_nxt = S_OWN;
         w_owner_nxt = w_win_idx;
         w_oe_nxt    = N_DRV'(1) << w_win_idx;
         w_hold_nxt  = 8'd0;
      end

      if (w_release) begin
         w_state_nxt = S_TURN;
         w_oe_nxt    = '0;
         w_rr_nxt    = (r_owner == LAST_IDX) ? '0 : r_owner + OW'(1);
         w_turn_nxt  = TURN_LOAD;
      end
   end

   assign w_grant_cnt_nxt = (w_grant && r_grant_cnt != 16'hFFFF) ? r_grant_cnt + 16'd1
                                                                  : r_grant_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_oe        <= '0;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_hold_cnt  <= 8'd0;
         r_turn_cnt  <= 4'd0;
         r_busy      <= 1'b0;
         r_preempt   <= 1'b0;
         r_grant_cnt <= 16'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_oe        <= w_oe_nxt;
         r_owner     <= w_owner_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_turn_cnt  <= w_turn_nxt;
         r_busy      <= (w_state_nxt == S_OWN);
         r_preempt   <= w_preempt_nxt;
         r_grant_cnt <= w_grant_cnt_nxt;
      end
   end

   assign o_oe        = r_oe;
   assign o_owner     = r_owner;
   assign o_bus_busy  = r_busy;
   assign o_preempt   = r_preempt;
   assign o_grant_cnt = r_grant_cnt;

endmodule
